idecompress: RTL
================

# idecompress

Sequential sparse-to-dense expander that rebuilds one dense column of signed samples from a stream of (value, column) entries. It is the inverse of the column compression stage, which keeps only samples at or above `1<<<LEFT_NUM` and stores them as right-shifted values with their column index. Sits on the consumer side of the compressed-column path. Entries arrive one per cycle under a valid/ready handshake, and the finished column is presented under a second handshake.

## Interface
- `W_OUT`, 128: number of columns in a dense vector.
- `SIZE_in_DATA`, 14: width of each reconstructed signed sample.
- `SIZE_val_DATA`, 8: width of the compressed value field.
- `SIZE_count`, 7: width of the column index (`clog2(W_OUT)`).
- `LEFT_NUM`, 8: left shift applied to restore magnitude.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a new column; sampled in IDLE only.
- `val_count`  in  SIZE_count+1  number of entries that follow; sampled with `start`.
- `in_valid`  in  1  entry present.
- `in_ready`  out  1  entry accepted this cycle when high together with `in_valid`.
- `in_val`  in  SIZE_val_DATA  compressed magnitude (unsigned).
- `in_col`  in  SIZE_count  destination column.
- `column_data`  out  signed [SIZE_in_DATA-1:0] x W_OUT  reconstructed column (registered).
- `out_valid`  out  1  `column_data` complete.
- `out_ready`  in  1  consumer takes the column.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  sticky error for the current column.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE to LOAD on `start` when `val_count` > 0. IDLE to DONE on `start` when `val_count` == 0.
- On `start`, in the same edge:
  - All `column_data` entries cleared to 0.
  - `err` cleared.
  - `remaining` loaded with `min(val_count, W_OUT)`.
  - If `val_count` > W_OUT, `err` is set.
- LOAD:
  - `in_ready` = 1. It is combinational from state and is 0 in IDLE and DONE.
  - Each accepted entry writes `column_data[in_col]` = zero-extended `in_val` shifted left by LEFT_NUM, truncated to SIZE_in_DATA bits.
  - Each accepted entry decrements `remaining`.
  - Accepting the entry that brings `remaining` to 0 moves the state to DONE.
- Writes with `in_col` >= W_OUT are dropped, set `err`, and still count toward `remaining`.
- Duplicate `in_col`: the later entry overwrites the earlier one. No error is raised.
- DONE: `out_valid` = 1 and `column_data` is held stable. `out_valid && out_ready` moves the state to IDLE. `column_data` keeps its value until the next `start`.
- `start` outside IDLE is ignored. A `start` in the same cycle as the DONE handshake is also ignored.
- Reset, including mid-LOAD or mid-DONE, applies these values and discards any partial column:
  - state = IDLE
  - all `column_data` = 0
  - `remaining` = 0
  - `out_valid` = 0, `in_ready` = 0, `busy` = 0, `err` = 0

## Timing
- `start` sampled at edge 0. `in_ready` is high from cycle 1.
- With N entries at full rate (accepted at edges 1..N), `out_valid` rises after edge N. First-entry-to-output latency is N cycles; throughput is 1 entry/cycle.
- With `val_count` = 0, `out_valid` is high in cycle 1 and `column_data` is all zero.
- Stalls on `in_valid` = 0 in LOAD are unlimited and leave state unchanged.
- After the output handshake edge, `out_valid` = 0 and `busy` = 0 in the next cycle. The earliest next `start` is accepted in that cycle.
- `err` updates on the same edge as the offending event and stays high until the next `start` or reset.

## Configuration
- Macro: `IDECOMPRESS_ORDER_CHECK_EN`.
- When defined:
  - A register holds the last accepted `in_col` for the current column.
  - An entry whose `in_col` is less than or equal to that value sets `err`. The write is still performed.
  - The check is skipped for the first entry after `start`.
- When undefined: no ordering register is present, and entry order has no effect on `err`.

## Test plan
- `start`, `val_count`=3; entries (1,0), (2,5), (255,127) back-to-back -> `out_valid` after edge 3; `column_data[0]`=256, `[5]`=512, `[127]`=65280 truncated to 14 bits = 16128 as unsigned bits; all other entries 0; `err`=0.
- `start`, `val_count`=0 -> `out_valid` in cycle 1, all 128 entries 0; hold `out_ready`=0 for 5 cycles -> outputs stable; then handshake -> `busy`=0.
- `val_count`=2; entries (3,9), (7,9) with `in_valid` gaps of 4 cycles -> `column_data[9]`=1792. `err` is 0 without the macro and 1 with it.
- `val_count`=200 -> clamped to 128 and `err`=1 immediately; after 128 entries -> DONE.
- Assert `rst_n`=0 after 2 of 4 entries -> immediately IDLE, `column_data` all 0, `out_valid`=0; a new column then completes normally.
- Drive `start` during LOAD and during the DONE handshake -> ignored; `val_count`/`remaining` are not reloaded.

Source files
------------

// File: rtl/idecompress_if.sv
// Handshake and column bus for the sparse-to-dense column expander.
// master drives entries and start; slave is the expander.
interface idecompress_if #(
  parameter int W_OUT         = 128,
  parameter int SIZE_in_DATA  = 14,
  parameter int SIZE_val_DATA = 8,
  parameter int SIZE_count    = 7
);
  logic                           start;
  logic [SIZE_count:0]            val_count;
  logic                           in_valid;
  logic                           in_ready;
  logic [SIZE_val_DATA-1:0]       in_val;
  logic [SIZE_count-1:0]          in_col;
  logic signed [SIZE_in_DATA-1:0] column_data [W_OUT];
  logic                           out_valid;
  logic                           out_ready;
  logic                           busy;
  logic                           err;

  modport master (
    output start, val_count, in_valid, in_val, in_col, out_ready,
    input  in_ready, column_data, out_valid, busy, err
  );

  modport slave (
    input  start, val_count, in_valid, in_val, in_col, out_ready,
    output in_ready, column_data, out_valid, busy, err
  );
endinterface

// File: rtl/idecompress.sv
// Sparse (value, column) stream to dense signed column expander.
// Optional macro IDECOMPRESS_ORDER_CHECK_EN flags non-ascending columns.
module idecompress #(
  parameter int W_OUT         = 128,
  parameter int SIZE_in_DATA  = 14,
  parameter int SIZE_val_DATA = 8,
  parameter int SIZE_count    = 7,
  parameter int LEFT_NUM      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  idecompress_if.slave bus
);

  localparam int CW = SIZE_count + 1;
  localparam int XW = SIZE_in_DATA + SIZE_val_DATA;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  remaining_q, remaining_d;
  logic                           err_q, err_d;
  logic signed [SIZE_in_DATA-1:0] col_q [W_OUT];
  logic signed [SIZE_in_DATA-1:0] col_d [W_OUT];
  logic [XW-1:0]                  ext;
  logic [SIZE_in_DATA-1:0]        wval;
  int                             idx;

`ifdef IDECOMPRESS_ORDER_CHECK_EN
  logic [SIZE_count-1:0]          last_col_q, last_col_d;
  logic                           first_q, first_d;
`endif

  assign bus.in_ready    = (state_q == LOAD);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;
  assign bus.column_data = col_q;

  // Restore magnitude of the incoming entry and locate its column.
  always_comb begin
    ext  = {{SIZE_in_DATA{1'b0}}, bus.in_val} << LEFT_NUM;
    wval = ext[SIZE_in_DATA-1:0];
    idx  = int'(bus.in_col);
  end

  // Next-state, column write and error tracking.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    col_d       = col_q;
`ifdef IDECOMPRESS_ORDER_CHECK_EN
    last_col_d  = last_col_q;
    first_d     = first_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < W_OUT; i++) col_d[i] = '0;
          if (bus.val_count > CW'(W_OUT)) begin
            err_d       = 1'b1;
            remaining_d = CW'(W_OUT);
          end else begin
            err_d       = 1'b0;
            remaining_d = bus.val_count;
          end
          state_d = (bus.val_count == '0) ? DONE : LOAD;
`ifdef IDECOMPRESS_ORDER_CHECK_EN
          first_d = 1'b1;
`endif
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          if (idx < W_OUT) col_d[idx] = wval;
          else             err_d      = 1'b1;
`ifdef IDECOMPRESS_ORDER_CHECK_EN
          if (!first_q && (bus.in_col <= last_col_q)) err_d = 1'b1;
          last_col_d = bus.in_col;
          first_d    = 1'b0;
`endif
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and column registers; reset discards any partial column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < W_OUT; i++) col_q[i] <= '0;
`ifdef IDECOMPRESS_ORDER_CHECK_EN
      last_col_q  <= '0;
      first_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      col_q       <= col_d;
`ifdef IDECOMPRESS_ORDER_CHECK_EN
      last_col_q  <= last_col_d;
      first_q     <= first_d;
`endif
    end
  end

endmodule
